// File: rtl/mips_defs_pkg.sv
// Shared MIPS encoding constants, mnemonic enum and word-packing helpers.
// The control decoder imports the same package, so both directions agree
// on every opcode and funct value.
package mips_defs;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // Mnemonic codes as presented on in_mnem; 11..15 are illegal
    typedef enum logic [3:0] {
        MN_ADD  = 4'd0,
        MN_SUB  = 4'd1,
        MN_SLT  = 4'd2,
        MN_JR   = 4'd3,
        MN_LW   = 4'd4,
        MN_SW   = 4'd5,
        MN_J    = 4'd6,
        MN_JAL  = 4'd7,
        MN_BEQ  = 4'd8,
        MN_BNE  = 4'd9,
        MN_XORI = 4'd10
    } mnem_e;

    // Occupancy of the two-entry output buffer
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    // R-type layout: opcode, rs, rt, rd, shamt (always zero here), funct
    function automatic logic [31:0] pack_r(input logic [4:0] rs,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd,
                                           input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

    // I-type layout: opcode, rs, rt, 16-bit immediate
    function automatic logic [31:0] pack_i(input logic [5:0]  op,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // J-type layout: opcode, 26-bit word target
    function automatic logic [31:0] pack_j(input logic [5:0]  op,
                                           input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational encoder: turns a mnemonic plus operand fields into a
// 32-bit MIPS word, and flags mnemonic codes that have no encoding.
module instr_pack
    import mips_defs::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] instr,
    output logic        illegal
);

    // Select the word layout for the mnemonic; unused fields are simply not packed
    always_comb begin
        instr   = '0;
        illegal = 1'b0;
        case (mnem)
            MN_ADD:  instr = pack_r(rs, rt, rd, FN_ADD);
            MN_SUB:  instr = pack_r(rs, rt, rd, FN_SUB);
            MN_SLT:  instr = pack_r(rs, rt, rd, FN_SLT);
            MN_JR:   instr = pack_r(rs, 5'd0, 5'd0, FN_JR);
            MN_LW:   instr = pack_i(OP_LW, rs, rt, imm);
            MN_SW:   instr = pack_i(OP_SW, rs, rt, imm);
            MN_BEQ:  instr = pack_i(OP_BEQ, rs, rt, imm);
            MN_BNE:  instr = pack_i(OP_BNE, rs, rt, imm);
            MN_XORI: instr = pack_i(OP_XORI, rs, rt, imm);
            MN_J:    instr = pack_j(OP_J, target);
            MN_JAL:  instr = pack_j(OP_JAL, target);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder and writer. Encodes each accepted request and hands
// the word, tagged with a sequential byte address, to the memory loader.
// An output register plus one skid register let in_ready be a pure flop
// output while never dropping or reordering words under backpressure.
module instr_encoder
    import mips_defs::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [15:0]       count
);

    logic [31:0] enc_instr;
    logic        enc_illegal;
    logic [31:0] skid_instr;
    logic        accept;
    logic        legal_accept;
    logic        emit;
    buf_state_e  state;
    buf_state_e  next_state;

    instr_pack u_pack (
        .mnem    (in_mnem),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .target  (in_target),
        .instr   (enc_instr),
        .illegal (enc_illegal)
    );

    // Handshake qualifiers; an illegal request is consumed but never buffered
    always_comb begin
        accept       = in_valid && in_ready;
        legal_accept = accept && !enc_illegal;
        emit         = out_valid && out_ready;
    end

    // Buffer occupancy for the next cycle; in_ready is registered from this
    always_comb begin
        next_state = state;
        case (state)
            BUF_EMPTY: begin
                if (legal_accept) next_state = BUF_ONE;
            end
            BUF_ONE: begin
                if (legal_accept && !emit)      next_state = BUF_TWO;
                else if (!legal_accept && emit) next_state = BUF_EMPTY;
            end
            BUF_TWO: begin
                if (emit) next_state = BUF_ONE;
            end
            default: next_state = BUF_EMPTY;
        endcase
    end

    // Buffer FSM with registered handshake outputs, address, count and error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BUF_EMPTY;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_instr  <= '0;
            skid_instr <= '0;
            out_addr   <= BASE_ADDR;
            count      <= '0;
            err        <= 1'b0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state != BUF_TWO);
            out_valid <= (next_state != BUF_EMPTY);

            case (state)
                BUF_EMPTY: begin
                    if (legal_accept) out_instr <= enc_instr;
                end
                BUF_ONE: begin
                    if (legal_accept && emit) out_instr  <= enc_instr;
                    else if (legal_accept)    skid_instr <= enc_instr;
                end
                BUF_TWO: begin
                    if (emit) out_instr <= skid_instr;
                end
                default: ;
            endcase

            if (emit) begin
                out_addr <= out_addr + ADDR_W'(4);
                if (count != 16'hFFFF) count <= count + 16'd1;
            end

            if (accept && enc_illegal) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: each accepted legal request pushes its
// expected word and address; the monitor pops and compares on every emit.
module tb_instr_encoder;
    import mips_defs::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_mnem;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;
    logic [15:0] count;

    logic        w_in_valid;
    logic        w_in_ready;
    logic        w_out_valid;
    logic [31:0] w_out_instr;
    logic [7:0]  w_out_addr;
    logic        w_err;
    logic [15:0] w_count;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] next_addr;
    int          exp_count;
    logic [31:0] mon_instr;
    logic [31:0] mon_addr;

    instr_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mnem   (in_mnem),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_imm    (in_imm),
        .in_target (in_target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err),
        .count     (count)
    );

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'hFC)) dut_wrap (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_mnem   (in_mnem),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_imm    (in_imm),
        .in_target (in_target),
        .out_valid (w_out_valid),
        .out_ready (1'b1),
        .out_instr (w_out_instr),
        .out_addr  (w_out_addr),
        .err       (w_err),
        .count     (w_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one request and hold it until the encoder takes it
    task automatic applyStimulus(input logic [3:0] mnem, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [15:0] imm, input logic [25:0] target,
                                 input logic [31:0] exp_word, input bit legal);
        bit taken = 0;
        in_mnem   = mnem;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_imm    = imm;
        in_target = target;
        in_valid  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (legal) begin
                    exp_instr_q.push_back(exp_word);
                    exp_addr_q.push_back(next_addr);
                    next_addr = next_addr + 32'd4;
                end
                taken = 1;
                break;
            end
        end
        if (!taken) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 100; i++) begin
            if (exp_instr_q.size() == 0) break;
            @(posedge clk);
            #2;
        end
        if (exp_instr_q.size() != 0) checkOutput("drain_timeout", exp_instr_q.size(), 32'd0);
    endtask

    task automatic doReset();
        in_valid   = 1'b0;
        w_in_valid = 1'b0;
        reset      = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        exp_instr_q.delete();
        exp_addr_q.delete();
        next_addr = 32'd0;
        exp_count = 0;
    endtask

    // Monitor: a valid word seen with out_ready high is emitted on the next edge
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_instr_q.size() == 0) begin
                checkOutput("unexpected_emit", 32'd1, 32'd0);
            end else begin
                mon_instr = exp_instr_q.pop_front();
                mon_addr  = exp_addr_q.pop_front();
                checkOutput("instr", out_instr, mon_instr);
                checkOutput("addr", out_addr, mon_addr);
                exp_count++;
            end
        end
    end

    initial begin
        logic [7:0] wrap_addr[2];
        logic [31:0] wrap_instr[2];
        int got;
        int acc;

        reset = 1'b1;
        in_valid = 1'b0;
        w_in_valid = 1'b0;
        out_ready = 1'b0;
        in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
        next_addr = 32'd0;
        exp_count = 0;

        // Reset values
        @(posedge clk);
        #2;
        checkOutput("rst_out_valid", out_valid, 32'd0);
        checkOutput("rst_in_ready", in_ready, 32'd0);
        checkOutput("rst_out_instr", out_instr, 32'd0);
        checkOutput("rst_out_addr", out_addr, 32'd0);
        checkOutput("rst_count", count, 32'd0);
        checkOutput("rst_err", err, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("rdy_after_release", in_ready, 32'd0);
        @(posedge clk);
        #2;
        checkOutput("rdy_first_edge", in_ready, 32'd1);

        // Streaming ADD then JR with one-cycle latency
        out_ready = 1'b1;
        applyStimulus(MN_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221820, 1);
        checkOutput("latency_add", out_valid, 32'd1);
        applyStimulus(MN_JR, 5'd31, 5'd7, 5'd9, 16'h1234, 26'h0, 32'h03E00008, 1);
        checkOutput("latency_jr", out_valid, 32'd1);
        waitDrain();
        checkOutput("count_stream", count, exp_count);

        // LW, J, JAL from a fresh reset
        doReset();
        out_ready = 1'b1;
        applyStimulus(MN_LW, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 32'h8FA80004, 1);
        applyStimulus(MN_J, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000, 32'h08100000, 1);
        applyStimulus(MN_JAL, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000, 32'h0C100000, 1);
        waitDrain();
        checkOutput("count_three", count, 32'd3);

        // Backpressure fills both entries and holds off a third request
        doReset();
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        applyStimulus(MN_XORI, 5'd4, 5'd5, 5'd0, 16'hFFFF, 26'h0, 32'h3885FFFF, 1);
        checkOutput("bp_rdy_one", in_ready, 32'd1);
        applyStimulus(MN_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFE, 26'h0, 32'h1022FFFE, 1);
        checkOutput("bp_rdy_two", in_ready, 32'd0);
        fork
            applyStimulus(MN_SUB, 5'd6, 5'd7, 5'd8, 16'h0, 26'h0, 32'h00C74022, 1);
            begin
                repeat (3) @(negedge clk);
                checkOutput("bp_held_off", in_ready, 32'd0);
                checkOutput("bp_hold_instr", out_instr, 32'h3885FFFF);
                checkOutput("bp_hold_addr", out_addr, 32'd0);
                @(posedge clk);
                #2;
                out_ready = 1'b1;
            end
        join
        waitDrain();
        checkOutput("bp_count", count, 32'd3);

        // Illegal mnemonic is swallowed and only sets err
        applyStimulus(4'hF, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 32'h0, 0);
        checkOutput("ill_err", err, 32'd1);
        checkOutput("ill_out_valid", out_valid, 32'd0);
        checkOutput("ill_count", count, 32'd3);
        checkOutput("ill_addr", out_addr, 32'd12);
        applyStimulus(MN_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221820, 1);
        applyStimulus(MN_SLT, 5'd9, 5'd10, 5'd11, 16'h0, 26'h0, 32'h012A582A, 1);
        applyStimulus(MN_SW, 5'd2, 5'd3, 5'd0, 16'h0010, 26'h0, 32'hAC430010, 1);
        applyStimulus(MN_BNE, 5'd3, 5'd0, 5'd0, 16'h8000, 26'h0, 32'h14608000, 1);
        waitDrain();
        checkOutput("post_ill_count", count, 32'd7);
        checkOutput("err_sticky", err, 32'd1);

        // Asynchronous reset while both entries are held
        out_ready = 1'b0;
        applyStimulus(MN_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221820, 1);
        applyStimulus(MN_SUB, 5'd6, 5'd7, 5'd8, 16'h0, 26'h0, 32'h00C74022, 1);
        checkOutput("two_rdy", in_ready, 32'd0);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_valid", out_valid, 32'd0);
        checkOutput("mid_rst_rdy", in_ready, 32'd0);
        checkOutput("mid_rst_err", err, 32'd0);
        exp_instr_q.delete();
        exp_addr_q.delete();
        next_addr = 32'd0;
        exp_count = 0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_rel_rdy", in_ready, 32'd0);
        @(posedge clk);
        #2;
        checkOutput("mid_rdy_edge", in_ready, 32'd1);
        out_ready = 1'b1;
        applyStimulus(MN_XORI, 5'd4, 5'd5, 5'd0, 16'hFFFF, 26'h0, 32'h3885FFFF, 1);
        waitDrain();
        checkOutput("mid_count", count, 32'd1);

        // Address wrap on the 8-bit instance starting at 0xFC
        doReset();
        in_mnem = MN_ADD; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3;
        got = 0;
        acc = 0;
        w_in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (w_out_valid && got < 2) begin
                wrap_addr[got]  = w_out_addr;
                wrap_instr[got] = w_out_instr;
                got++;
            end
            if (w_in_valid && w_in_ready) acc++;
            @(posedge clk);
            #2;
            if (acc >= 2) w_in_valid = 1'b0;
            if (got == 2) break;
        end
        w_in_valid = 1'b0;
        checkOutput("wrap_got", got, 32'd2);
        if (got == 2) begin
            checkOutput("wrap_addr0", {24'd0, wrap_addr[0]}, 32'h000000FC);
            checkOutput("wrap_addr1", {24'd0, wrap_addr[1]}, 32'h00000000);
            checkOutput("wrap_instr0", wrap_instr[0], 32'h00221820);
            checkOutput("wrap_instr1", wrap_instr[1], 32'h00221820);
        end
        checkOutput("wrap_count", w_count, 32'd2);
        checkOutput("wrap_addr_next", {24'd0, w_out_addr}, 32'h00000004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
